// File: rtl/heard_ser_pkg.sv
// Shared types and helpers for the heard indication serializer.
package heard_ser_pkg;

  localparam int unsigned METH_W        = 16;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MSG_WORDS_DEF = 2;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  typedef struct packed {
    logic [METH_W-1:0] meth;
    logic [DATA_W-1:0] v;
  } entry_t;

  // Header word: message length in the upper half, method id in the lower half.
  function automatic logic [DATA_W-1:0] hdr(input logic [METH_W-1:0] meth,
                                           input logic [15:0] words = 16'(MSG_WORDS_DEF));
    return {words, meth};
  endfunction

endpackage

// File: rtl/heard_ser_fifo.sv
// Generic synchronous FIFO with an unregistered head output.
module heard_ser_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; count carries one extra bit to tell full from empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/heard_ind_serializer.sv
// Buffers heard(meth, v) indications and emits each as a header + payload word.
// Optional HEARD_SER_STATS_EN adds a saturating drop_count for illegal method ids.
module heard_ind_serializer
  import heard_ser_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned METH_COUNT = 10,
  parameter int unsigned MSG_WORDS  = MSG_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        msg_enq__ENA,
  output logic [31:0] msg_enq_v,
  input  logic        msg_enq__RDY
`ifdef HEARD_SER_STATS_EN
  ,output logic [15:0] drop_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t          state;
  entry_t          push_entry;
  entry_t          head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            legal;
  logic            accept;
  logic            push_c;
  logic            pop_c;
  logic [31:0]     out_v;

  assign heard__RDY = (count != CW'(DEPTH));
  assign legal      = (heard_meth < 32'(METH_COUNT));
  assign accept     = heard__ENA && heard__RDY;
  assign push_c     = accept && legal && !full;
  assign pop_c      = !empty && ((state == IDLE) || (state == DATA && msg_enq__RDY));

  always_comb begin
    push_entry      = '0;
    push_entry.meth = heard_meth[15:0];
    push_entry.v    = heard_v;
  end

  heard_ser_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push_c),
    .din   (push_entry),
    .pop   (pop_c),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Message FSM: the header is built at load time, the payload waits in out_v.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      msg_enq__ENA <= 1'b0;
      msg_enq_v    <= '0;
      out_v        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            out_v        <= head.v;
            msg_enq_v    <= hdr(head.meth, 16'(MSG_WORDS));
            msg_enq__ENA <= 1'b1;
            state        <= HDR;
          end
        end
        HDR: begin
          if (msg_enq__RDY) begin
            msg_enq_v <= out_v;
            state     <= DATA;
          end
        end
        DATA: begin
          if (msg_enq__RDY) begin
            if (!empty) begin
              out_v     <= head.v;
              msg_enq_v <= hdr(head.meth, 16'(MSG_WORDS));
              state     <= HDR;
            end else begin
              msg_enq__ENA <= 1'b0;
              msg_enq_v    <= '0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          msg_enq__ENA <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef HEARD_SER_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      drop_count <= '0;
    end else if (accept && !legal && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_heard_ind_serializer.sv
// Scoreboard bench for heard_ind_serializer; checks drop_count when HEARD_SER_STATS_EN is defined.
module tb_heard_ind_serializer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        msg_enq__ENA;
  logic [31:0] msg_enq_v;
  logic        msg_enq__RDY;
`ifdef HEARD_SER_STATS_EN
  logic [15:0] drop_count;
`endif

  int          checks = 0;
  int          errors = 0;
  int          exp_drops = 0;
  bit          rand_sink = 1'b0;
  logic [31:0] exp_q [$];

  heard_ind_serializer dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .heard__ENA   (heard__ENA),
    .heard_meth   (heard_meth),
    .heard_v      (heard_v),
    .heard__RDY   (heard__RDY),
    .msg_enq__ENA (msg_enq__ENA),
    .msg_enq_v    (msg_enq_v),
    .msg_enq__RDY (msg_enq__RDY)
`ifdef HEARD_SER_STATS_EN
    ,.drop_count  (drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_sink) msg_enq__RDY = ($urandom_range(0, 9) < 7);
  endtask

  // Holds one indication until it is handshaken.
  task automatic send(input logic [31:0] meth, input logic [31:0] v);
    int n = 0;
    heard__ENA = 1'b1;
    heard_meth = meth;
    heard_v    = v;
    while (!heard__RDY && n < 500) begin
      tick();
      n++;
    end
    if (!heard__RDY) chk("send_timeout", 32'(heard__RDY), 32'd1);
    tick();
    heard__ENA = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    if (!rand_sink) msg_enq__RDY = 1'b1;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    chk("idle_ena", 32'(msg_enq__ENA), 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_ena", 32'(msg_enq__ENA), 32'd0);
    chk("rst_v", msg_enq_v, 32'd0);
    exp_q.delete();
    exp_drops = 0;
`ifdef HEARD_SER_STATS_EN
    chk("rst_drop", 32'(drop_count), 32'd0);
`endif
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    chk("rdy_after_rst", 32'(heard__RDY), 32'd1);
  endtask

  // Monitor: outputs are checked before this cycle's input is recorded.
  initial begin
    logic        pe;
    logic        pr;
    logic [31:0] pv;
    logic [31:0] w;
    pe = 1'b0; pr = 1'b0; pv = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        pe = 1'b0;
      end else begin
        if (pe && !pr) begin
          checks++;
          if (!(msg_enq__ENA === 1'b1 && msg_enq_v === pv)) begin
            errors++;
            $display("FAIL stall_hold actual ena=%b v=%h required ena=1 v=%h", msg_enq__ENA, msg_enq_v, pv);
          end
        end
        if (msg_enq__ENA && msg_enq__RDY) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", msg_enq_v);
          end else begin
            w = exp_q.pop_front();
            if (msg_enq_v !== w) begin
              errors++;
              $display("FAIL word actual=%h required=%h", msg_enq_v, w);
            end
          end
        end
        if (heard__ENA && heard__RDY) begin
          if (heard_meth < 32'd10) begin
            exp_q.push_back(32'h0002_0000 | heard_meth);
            exp_q.push_back(heard_v);
          end else begin
            exp_drops++;
          end
        end
        pe = msg_enq__ENA;
        pr = msg_enq__RDY;
        pv = msg_enq_v;
      end
    end
  end

  initial begin
    int acc;
    int n;
    heard__ENA   = 1'b0;
    heard_meth   = '0;
    heard_v      = '0;
    msg_enq__RDY = 1'b0;
    nRST         = 1'b0;
    #2;
    do_reset();

    // Single message with a ready sink.
    msg_enq__RDY = 1'b1;
    send(32'd3, 32'hDEAD_BEEF);
    drain();

    // Header stalled for five cycles.
    msg_enq__RDY = 1'b0;
    send(32'd3, 32'hDEAD_BEEF);
    n = 0;
    while (!msg_enq__ENA && n < 50) begin tick(); n++; end
    repeat (5) tick();
    chk("hdr_held", msg_enq_v, 32'h0002_0003);
    drain();

    // Fill with a stalled sink: one entry in the out register plus DEPTH queued.
    msg_enq__RDY = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      heard__ENA = 1'b1;
      heard_meth = 32'(i);
      heard_v    = $urandom;
      if (heard__RDY) acc++;
      tick();
    end
    heard__ENA = 1'b0;
    chk("fill_accepts", 32'(acc), 32'd5);
    chk("full_rdy", 32'(heard__RDY), 32'd0);
    msg_enq__RDY = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("b2b_cycles", 32'(n), 32'd10);
    drain();

    // Illegal ids are consumed and dropped.
    send(32'd10, 32'h1);
    send(32'd9, 32'h2);
    send(32'h0001_0003, 32'h3);
    drain();
`ifdef HEARD_SER_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(exp_drops));
`endif

    // Reset while the payload word is presented.
    msg_enq__RDY = 1'b0;
    send(32'd5, 32'h1234_5678);
    n = 0;
    while (!msg_enq__ENA && n < 50) begin tick(); n++; end
    msg_enq__RDY = 1'b1;
    tick();
    msg_enq__RDY = 1'b0;
    chk("data_word", msg_enq_v, 32'h1234_5678);
    do_reset();
    send(32'd7, 32'hCAFE_F00D);
    drain();

    // Randomized traffic with a random sink.
    rand_sink = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r < 13)       send(32'(r), $urandom);
      else if (r == 13) send(32'hFFFF_FFFF, $urandom);
      else              send(32'h0001_0000 + 32'(r), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    drain();
    rand_sink = 1'b0;
`ifdef HEARD_SER_STATS_EN
    chk("drop_count_rand", 32'(drop_count), 32'(exp_drops));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
